// File: rtl/uart_pkg.sv
// Shared UART definitions for the receive core and the future transmit core.
// Contents:
//    UART_DATA_BITS        data bits per frame (8N1 framing)
//    DEFAULT_CLKS_PER_BIT  clocks per bit at 40 MHz / 9600 baud
//    uart_rx_state_t       receiver state encoding
package uart_pkg;

   localparam int UART_DATA_BITS       = 8;
   localparam int DEFAULT_CLKS_PER_BIT = 4167;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP,
      RX_WAIT_IDLE
   } uart_rx_state_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// Small synchronous FIFO holding received bytes until firmware pops them.
// Ports:
//    clock, reset   single clock, synchronous active-high reset
//    push, pushData write request and data; ignored when full unless a pop
//                   happens in the same cycle
//    pop, popData   read request and head-of-queue data; pop when empty is ignored
//    full, empty    occupancy flags
//    level          number of entries held, 0..DEPTH
module uart_rx_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         pushData,
   input  logic                     pop,
   output logic [WIDTH-1:0]         popData,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] LEVEL_MAX = (PTR_W + 1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wrPtr;
   logic [PTR_W-1:0] rdPtr;
   logic             doPush;
   logic             doPop;

   // A pop frees a slot in the same cycle, so a push is still accepted when
   // the queue is full as long as the head is leaving at the same time.
   assign empty   = (level == '0);
   assign full    = (level == LEVEL_MAX);
   assign doPop   = pop && !empty;
   assign doPush  = push && (!full || doPop);
   assign popData = mem[rdPtr];

   // Storage, pointers and occupancy. Pointers wrap naturally because DEPTH
   // is a power of two; the level counter is tracked separately so full and
   // empty never alias. Storage is cleared on reset so the head reads zero.
   always_ff @(posedge clock) begin
      if (reset) begin
         wrPtr <= '0;
         rdPtr <= '0;
         level <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (doPush) begin
            mem[wrPtr] <= pushData;
            wrPtr      <= wrPtr + PTR_W'(1);
         end
         if (doPop) begin
            rdPtr <= rdPtr + PTR_W'(1);
         end
         case ({doPush, doPop})
            2'b10:   level <= level + (PTR_W + 1)'(1);
            2'b01:   level <= level - (PTR_W + 1)'(1);
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver with a receive FIFO, sampling each bit at its centre.
// Ports:
//    wb_clk_i, wb_rst_i  clock and synchronous active-high reset
//    rx_i                asynchronous serial line, idle high
//    rx_data_o           head-of-FIFO byte, meaningful while rx_valid_o
//    rx_valid_o          FIFO non-empty
//    rx_ready_i          consumer pop; pop happens when rx_valid_o && rx_ready_i
//    fifo_level_o        entries held, 0..FIFO_DEPTH
//    frame_err_o         one-cycle pulse, stop bit sampled low
//    overrun_o           one-cycle pulse, good byte dropped because FIFO full
//    busy_o              receiver not idle
//    irq_o               level interrupt, same as rx_valid_o
module uart_rx_core
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                          wb_clk_i,
   input  logic                          wb_rst_i,
   input  logic                          rx_i,
   output logic [UART_DATA_BITS-1:0]     rx_data_o,
   output logic                          rx_valid_o,
   input  logic                          rx_ready_i,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
   output logic                          frame_err_o,
   output logic                          overrun_o,
   output logic                          busy_o,
   output logic                          irq_o
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam int IDX_W = $clog2(UART_DATA_BITS);
   localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] LAST_BIT  = IDX_W'(UART_DATA_BITS - 1);

   logic                      rxMeta;
   logic                      rxSync;
   uart_rx_state_t            state;
   uart_rx_state_t            stateNext;
   logic [CNT_W-1:0]          bitCnt;
   logic [CNT_W-1:0]          bitCntNext;
   logic [IDX_W-1:0]          bitIdx;
   logic [IDX_W-1:0]          bitIdxNext;
   logic [UART_DATA_BITS-1:0] shiftReg;
   logic [UART_DATA_BITS-1:0] shiftRegNext;
   logic                      cntZero;
   logic                      pushByte;
   logic                      frameErrNext;
   logic                      frameErrReg;
   logic                      overrunReg;
   logic                      fifoFull;
   logic                      fifoEmpty;

   // Two-flop synchronizer for the asynchronous line. Both flops reset high
   // so a reset never looks like a start edge.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         rxMeta <= 1'b1;
         rxSync <= 1'b1;
      end else begin
         rxMeta <= rx_i;
         rxSync <= rxMeta;
      end
   end

   // Receiver state, bit timer, bit index and shift register, plus the
   // registered error pulses. Overrun is only flagged when the FIFO is full
   // and the consumer is not popping in the same cycle, since a simultaneous
   // pop makes room for the new byte.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state       <= RX_IDLE;
         bitCnt      <= '0;
         bitIdx      <= '0;
         shiftReg    <= '0;
         frameErrReg <= 1'b0;
         overrunReg  <= 1'b0;
      end else begin
         state       <= stateNext;
         bitCnt      <= bitCntNext;
         bitIdx      <= bitIdxNext;
         shiftReg    <= shiftRegNext;
         frameErrReg <= frameErrNext;
         overrunReg  <= pushByte && fifoFull && !rx_ready_i;
      end
   end

   assign cntZero = (bitCnt == '0);

   // Next-state logic. The start bit is timed with a half-bit load so every
   // later sample lands mid-bit; reloading a full bit after that keeps the
   // samples centred. The stop bit is judged at its centre and the receiver
   // returns to idle right there, which leaves half a bit of margin to catch
   // a back-to-back start edge. A low stop bit parks the receiver until the
   // line goes high so a long break reports only one framing error.
   always_comb begin
      stateNext    = state;
      bitCntNext   = bitCnt;
      bitIdxNext   = bitIdx;
      shiftRegNext = shiftReg;
      pushByte     = 1'b0;
      frameErrNext = 1'b0;
      case (state)
         RX_IDLE: begin
            if (!rxSync) begin
               bitCntNext = HALF_LOAD;
               stateNext  = RX_START;
            end
         end
         RX_START: begin
            if (cntZero) begin
               if (!rxSync) begin
                  bitCntNext = FULL_LOAD;
                  bitIdxNext = '0;
                  stateNext  = RX_DATA;
               end else begin
                  stateNext  = RX_IDLE;
               end
            end else begin
               bitCntNext = bitCnt - CNT_W'(1);
            end
         end
         RX_DATA: begin
            if (cntZero) begin
               shiftRegNext = {rxSync, shiftReg[UART_DATA_BITS-1:1]};
               bitCntNext   = FULL_LOAD;
               if (bitIdx == LAST_BIT) begin
                  stateNext  = RX_STOP;
               end else begin
                  bitIdxNext = bitIdx + IDX_W'(1);
               end
            end else begin
               bitCntNext = bitCnt - CNT_W'(1);
            end
         end
         RX_STOP: begin
            if (cntZero) begin
               if (rxSync) begin
                  pushByte     = 1'b1;
                  stateNext    = RX_IDLE;
               end else begin
                  frameErrNext = 1'b1;
                  stateNext    = RX_WAIT_IDLE;
               end
            end else begin
               bitCntNext = bitCnt - CNT_W'(1);
            end
         end
         RX_WAIT_IDLE: begin
            if (rxSync) begin
               stateNext = RX_IDLE;
            end
         end
         default: begin
            stateNext = RX_IDLE;
         end
      endcase
   end

   // Receive queue between the deserializer and the firmware pop interface.
   uart_rx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (UART_DATA_BITS)
   ) rxFifo (
      .clock    (wb_clk_i),
      .reset    (wb_rst_i),
      .push     (pushByte),
      .pushData (shiftReg),
      .pop      (rx_ready_i),
      .popData  (rx_data_o),
      .full     (fifoFull),
      .empty    (fifoEmpty),
      .level    (fifo_level_o)
   );

   assign rx_valid_o  = !fifoEmpty;
   assign irq_o       = !fifoEmpty;
   assign busy_o      = (state != RX_IDLE);
   assign frame_err_o = frameErrReg;
   assign overrun_o   = overrunReg;

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core with CLKS_PER_BIT=16, FIFO_DEPTH=4.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_uart_rx_core;

   localparam int CPB   = 16;
   localparam int DEPTH = 4;

   typedef struct {
      logic [7:0]  data;
      bit          stopOk;
      int          expLevel;
      int          expErr;
      int          expOvr;
      int          popN;
      logic [31:0] popBytes;
   } frameVec_t;

   logic       clock = 1'b0;
   logic       reset;
   logic       rxLine;
   logic       ready;
   logic [7:0] rx_data_o;
   logic       rx_valid_o;
   logic [2:0] fifo_level_o;
   logic       frame_err_o;
   logic       overrun_o;
   logic       busy_o;
   logic       irq_o;

   int vecCount      = 0;
   int missCount     = 0;
   int frameErrCount = 0;
   int overrunCount  = 0;
   int latency;
   int errBase;
   int ovrBase;
   int expErr;
   int expOvr;
   int popsNow;
   logic [7:0] randByte;
   bit         randOk;
   logic [7:0] model [$];
   frameVec_t  vecs [9];

   uart_rx_core #(
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (DEPTH)
   ) dut (
      .wb_clk_i     (clock),
      .wb_rst_i     (reset),
      .rx_i         (rxLine),
      .rx_data_o    (rx_data_o),
      .rx_valid_o   (rx_valid_o),
      .rx_ready_i   (ready),
      .fifo_level_o (fifo_level_o),
      .frame_err_o  (frame_err_o),
      .overrun_o    (overrun_o),
      .busy_o       (busy_o),
      .irq_o        (irq_o)
   );

   // Free-running clock, 10 time units per cycle.
   always #5 clock = ~clock;

   // Count cycles during which each error pulse is high; a stretched pulse
   // therefore shows up as an extra count.
   always @(negedge clock) begin
      if (frame_err_o) frameErrCount++;
      if (overrun_o) overrunCount++;
   end

   // Hang guard.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      vecCount++;
      if (actual !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Drive one 8N1 frame: start, 8 data bits LSB first, stop. The line is
   // left at the stop level so a low stop can be stretched into a break.
   task automatic applyStimulus(input logic [7:0] data, input bit stopOk);
      rxLine = 1'b0;
      tick(CPB);
      for (int b = 0; b < 8; b++) begin
         rxLine = data[b];
         tick(CPB);
      end
      rxLine = stopOk;
      tick(CPB);
   endtask

   task automatic popOne(input logic [7:0] expected, input string name);
      checkOutput({name, "_valid"}, rx_valid_o, 1);
      checkOutput(name, rx_data_o, expected);
      ready = 1'b1;
      tick(1);
      ready = 1'b0;
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_data"},     rx_data_o,    0);
      checkOutput({tag, "_valid"},    rx_valid_o,   0);
      checkOutput({tag, "_level"},    fifo_level_o, 0);
      checkOutput({tag, "_frameerr"}, frame_err_o,  0);
      checkOutput({tag, "_overrun"},  overrun_o,    0);
      checkOutput({tag, "_busy"},     busy_o,       0);
      checkOutput({tag, "_irq"},      irq_o,        0);
   endtask

   initial begin
      vecs[0] = '{8'h3D, 1'b1, 1, 0, 0, 0, 32'h0};
      vecs[1] = '{8'h4F, 1'b1, 2, 0, 0, 0, 32'h0};
      vecs[2] = '{8'h29, 1'b1, 3, 0, 0, 3, 32'h00294F3D};
      vecs[3] = '{8'h01, 1'b1, 1, 0, 0, 0, 32'h0};
      vecs[4] = '{8'h02, 1'b1, 2, 0, 0, 0, 32'h0};
      vecs[5] = '{8'h03, 1'b1, 3, 0, 0, 0, 32'h0};
      vecs[6] = '{8'h04, 1'b1, 4, 0, 0, 0, 32'h0};
      vecs[7] = '{8'h05, 1'b1, 4, 0, 1, 4, 32'h04030201};
      vecs[8] = '{8'hC3, 1'b0, 0, 1, 0, 0, 32'h0};

      reset  = 1'b1;
      rxLine = 1'b1;
      ready  = 1'b0;
      tick(3);
      checkResetValues("por");
      reset = 1'b0;
      tick(2);

      // First byte: latency from falling edge to rx_valid_o.
      fork
         applyStimulus(8'h0F, 1'b1);
         begin
            latency = 0;
            while (!rx_valid_o && latency < 400) begin
               tick(1);
               latency++;
            end
         end
      join
      checkOutput("first_latency", latency, 2 + 8 + 9 * CPB + 1);
      checkOutput("first_data", rx_data_o, 8'h0F);
      checkOutput("first_level", fifo_level_o, 1);
      checkOutput("first_irq", irq_o, 1);
      checkOutput("first_busy", busy_o, 0);
      popOne(8'h0F, "first_pop");
      checkOutput("first_empty", rx_valid_o, 0);

      // Table: back-to-back frames, ordering, overrun, framing error.
      for (int i = 0; i < 9; i++) begin
         errBase = frameErrCount;
         ovrBase = overrunCount;
         applyStimulus(vecs[i].data, vecs[i].stopOk);
         if (!vecs[i].stopOk) begin
            rxLine = 1'b1;
            tick(CPB);
         end
         checkOutput($sformatf("vec%0d_level", i), fifo_level_o, vecs[i].expLevel);
         checkOutput($sformatf("vec%0d_frameerr", i), frameErrCount - errBase, vecs[i].expErr);
         checkOutput($sformatf("vec%0d_overrun", i), overrunCount - ovrBase, vecs[i].expOvr);
         for (int j = 0; j < vecs[i].popN; j++) begin
            popOne(vecs[i].popBytes[8*j +: 8], $sformatf("vec%0d_pop%0d", i, j));
         end
         checkOutput($sformatf("vec%0d_after_pop_level", i), fifo_level_o, vecs[i].expLevel - vecs[i].popN);
         checkOutput($sformatf("vec%0d_after_pop_valid", i), rx_valid_o, (vecs[i].expLevel - vecs[i].popN) > 0);
      end

      // Push and pop in the same cycle while full.
      for (int i = 1; i <= 4; i++) applyStimulus(8'(i * 8'h11), 1'b1);
      checkOutput("full_level", fifo_level_o, 4);
      ovrBase = overrunCount;
      fork
         applyStimulus(8'h55, 1'b1);
         begin
            tick(2 + 8 + 9 * CPB);
            checkOutput("full_head_at_push", rx_data_o, 8'h11);
            ready = 1'b1;
            tick(1);
            ready = 1'b0;
         end
      join
      checkOutput("full_pushpop_overrun", overrunCount - ovrBase, 0);
      checkOutput("full_pushpop_level", fifo_level_o, 4);
      popOne(8'h22, "full_pop1");
      popOne(8'h33, "full_pop2");
      popOne(8'h44, "full_pop3");
      popOne(8'h55, "full_pop4");

      // Framing error followed by a held-low break.
      errBase = frameErrCount;
      applyStimulus(8'hA5, 1'b0);
      tick(3 * CPB);
      checkOutput("break_busy", busy_o, 1);
      checkOutput("break_level", fifo_level_o, 0);
      rxLine = 1'b1;
      tick(4);
      checkOutput("break_busy_released", busy_o, 0);
      checkOutput("break_frameerr_count", frameErrCount - errBase, 1);

      // Short glitch on an idle line.
      errBase = frameErrCount;
      rxLine = 1'b0;
      tick(4);
      checkOutput("glitch_busy_seen", busy_o, 1);
      rxLine = 1'b1;
      tick(10);
      checkOutput("glitch_busy_cleared", busy_o, 0);
      tick(10 * CPB);
      checkOutput("glitch_valid", rx_valid_o, 0);
      checkOutput("glitch_frameerr", frameErrCount - errBase, 0);

      // Reset in the middle of DATA bit 4 with a byte already queued.
      applyStimulus(8'h5A, 1'b1);
      checkOutput("prereset_level", fifo_level_o, 1);
      fork
         applyStimulus(8'hFF, 1'b1);
         begin
            tick(CPB + 4 * CPB + 8);
            checkOutput("prereset_busy", busy_o, 1);
            reset = 1'b1;
            tick(1);
            checkResetValues("midreset");
            reset = 1'b0;
         end
      join
      tick(2);
      checkOutput("postreset_valid", rx_valid_o, 0);
      applyStimulus(8'h29, 1'b1);
      checkOutput("postreset_level", fifo_level_o, 1);
      popOne(8'h29, "postreset_pop");

      // Randomized frames against a queue model of the receive FIFO.
      model.delete();
      expErr  = 0;
      expOvr  = 0;
      errBase = frameErrCount;
      ovrBase = overrunCount;
      for (int n = 0; n < 24; n++) begin
         randByte = 8'($urandom_range(0, 255));
         randOk   = ($urandom_range(0, 5) != 0);
         applyStimulus(randByte, randOk);
         if (randOk) begin
            if (model.size() < DEPTH) model.push_back(randByte);
            else expOvr++;
         end else begin
            expErr++;
            rxLine = 1'b1;
            tick(CPB);
         end
         tick($urandom_range(0, 3));
         checkOutput($sformatf("rand%0d_level", n), fifo_level_o, model.size());
         popsNow = $urandom_range(0, 2);
         for (int p = 0; p < popsNow; p++) begin
            if (model.size() > 0) begin
               popOne(model.pop_front(), $sformatf("rand%0d_pop", n));
            end else begin
               checkOutput($sformatf("rand%0d_empty_valid", n), rx_valid_o, 0);
               ready = 1'b1;
               tick(1);
               ready = 1'b0;
               checkOutput($sformatf("rand%0d_empty_level", n), fifo_level_o, 0);
            end
         end
      end
      checkOutput("rand_frameerr_total", frameErrCount - errBase, expErr);
      checkOutput("rand_overrun_total", overrunCount - ovrBase, expOvr);
      while (model.size() > 0) popOne(model.pop_front(), "rand_drain");
      checkOutput("rand_drained_valid", rx_valid_o, 0);

      $display("[TB] == %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule

// File: doc/uart_rx_core.md
# uart_rx_core

Synthesizable 8N1 UART receiver with a small receive FIFO, placed in the user project area behind the Wishbone UART register block. It deserializes the line driven by the testbench UART transmitter on `mprj_io[5]`, validates start and stop bits, and queues received bytes for firmware through a valid/ready pop interface. Framing errors and FIFO overrun are reported as single-cycle pulses for the status/interrupt logic.

## Interface
- `CLKS_PER_BIT`, 4167: clock cycles per bit (40 MHz / 9600 baud); minimum 8.
- `FIFO_DEPTH`, 4: receive FIFO entries; power of two, minimum 2.
- `wb_clk_i  in  1`: single clock.
- `wb_rst_i  in  1`: reset, synchronous, active-high.
- `rx_i  in  1`: asynchronous serial line, idle high.
- `rx_data_o  out  8`: head-of-FIFO byte; valid only while `rx_valid_o`.
- `rx_valid_o  out  1`: FIFO non-empty.
- `rx_ready_i  in  1`: consumer pop; pop occurs when `rx_valid_o && rx_ready_i`.
- `fifo_level_o  out  $clog2(FIFO_DEPTH)+1`: entries held, 0..FIFO_DEPTH.
- `frame_err_o  out  1`: one-cycle pulse, stop bit sampled low.
- `overrun_o  out  1`: one-cycle pulse, good byte dropped because FIFO full.
- `busy_o  out  1`: receiver not in IDLE.
- `irq_o  out  1`: level, equal to `rx_valid_o`.

## Operation
- `rx_i` passes through a 2-flop synchronizer (both flops reset to 1); all logic uses the synchronized value `rx_s`.
- States: IDLE, START, DATA, STOP, WAIT_IDLE.
- IDLE: on `rx_s == 0` load bit counter with CLKS_PER_BIT/2 - 1, go START.
- START: at counter zero sample `rx_s`; 0 -> DATA (counter = CLKS_PER_BIT-1, bit index 0); 1 -> IDLE (glitch rejected, no error).
- DATA: at each counter zero shift `rx_s` in LSB first; after bit 7 go STOP.
- STOP: at counter zero sample; 1 -> push byte, go IDLE; 0 -> pulse `frame_err_o`, discard byte, go WAIT_IDLE.
- WAIT_IDLE: stay until `rx_s == 1`, then IDLE (a held-low break yields exactly one frame error).
- Push when FIFO full and no pop in that cycle: drop new byte, pulse `overrun_o`; stored entries untouched.
- Push and pop in the same cycle: always accepted, including when full; level unchanged.
- FIFO pointers wrap modulo FIFO_DEPTH; level is a separate counter, never exceeds FIFO_DEPTH or underflows.
- Pop when empty is ignored.

## Timing
- Reset values: `rx_data_o` 0, `rx_valid_o` 0, `fifo_level_o` 0, `frame_err_o` 0, `overrun_o` 0, `busy_o` 0, `irq_o` 0; state IDLE; FIFO emptied.
- Reset mid-frame aborts the frame; no partial byte is pushed; next start edge after reset is received normally.
- Sampling at bit centre: start-edge-to-sample latency = 2 sync cycles + CLKS_PER_BIT/2 + n·CLKS_PER_BIT.
- Byte push at the stop-bit sample cycle; `rx_valid_o`/`rx_data_o` update on the following edge (1-cycle latency).
- Pop: `rx_data_o` shows next entry and `fifo_level_o` decrements on the edge after the handshake.
- Error pulses are registered, asserted exactly one cycle, aligned to the stop-sample cycle + 1.
- Back-to-back frames with zero idle time are received without loss (IDLE is re-entered at mid-stop-bit).

## Structure
- Shared `uart_pkg`: state enum `uart_rx_state_t`, `UART_DATA_BITS = 8`, default `CLKS_PER_BIT` constant, shared with the future TX core.
- Sub-module `uart_rx_fifo` (synchronous FIFO, parameter DEPTH/WIDTH, push/pop/full/empty/level); receiver FSM, synchronizer and shift register stay in `uart_rx_core`.

## Test plan
Bench uses CLKS_PER_BIT=16, FIFO_DEPTH=4.
- Send 0x0F, `rx_ready_i`=0 -> `rx_valid_o`=1, `rx_data_o`=0x0F, level 1, exactly 2+8+9·16+1 cycles after falling edge.
- Send 0x3D, 0x4F, 0x29 back-to-back, no pop -> level 3; pop yields 0x3D, 0x4F, 0x29 in order, then `rx_valid_o`=0.
- Send 5 bytes 0x01..0x05 without pop -> one `overrun_o` pulse on byte 5, level 4, pops return 0x01..0x04.
- Frame 0xA5 with stop bit low, line held low 3 bit times -> one `frame_err_o` pulse, level 0, `busy_o` high until line rises.
- 4-cycle low glitch on idle line -> no push, no error, `busy_o` returns 0 within 10 cycles.
- Assert `wb_rst_i` during DATA bit 4 of 0xFF -> all outputs at reset values; next frame 0x29 received correctly.
